regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, writeback queue entries (power of 2, minimum 2).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports memValid, memReg, memData  input  1/5/64  load-unit result: valid, destination, data.
REQ-005 The block SHALL have port memReady  output  1  queue accepts the load result this cycle.
REQ-006 The block SHALL have ports aluValid, aluReg, aluData  input  1/5/64  ALU result: valid, destination, data.
REQ-007 The block SHALL have port aluReady  output  1  queue accepts the ALU result this cycle.
REQ-008 The block SHALL have ports writeReg, writeData, allowWrite  output  5/64/1  register-file write port, registered.
REQ-009 The block SHALL have ports count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-010 A transfer SHALL occur on a rising edge where valid and ready are both high; a source SHALL hold reg/data stable while valid and not ready.
REQ-011 memReady SHALL be (count < DEPTH), from registered count only; no credit for a same-cycle dequeue.
REQ-012 aluReady SHALL be (count < DEPTH-1), or (count < DEPTH and memValid low).
REQ-013 On a simultaneous mem and ALU transfer, the mem entry SHALL be enqueued first (older), the ALU entry second.
REQ-014 A transfer with destination 0 SHALL complete the handshake but SHALL NOT be enqueued.
REQ-015 Each cycle with count > 0, the head entry SHALL be popped and loaded into writeReg/writeData with allowWrite=1 on the next edge.
REQ-016 When count = 0, allowWrite SHALL be 0 on the next edge; writeReg/writeData SHALL hold their last values.
REQ-017 Latency SHALL be one cycle: an entry enqueued into an empty queue at edge N SHALL appear at the write port after edge N+1.
REQ-018 Writes SHALL reach the write port in enqueue order; one write per cycle maximum.
REQ-019 count SHALL update as count + enqueued - popped in the same edge; 0, 1 or 2 enqueues and 0 or 1 pop per edge.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 Enqueue into a full queue SHALL be impossible by REQ-011/012; no entry SHALL be dropped or overwritten.

Reset
REQ-022 On rst_n low, asynchronously: count=0, pointers=0, allowWrite=0, writeReg=0, writeData=0.
REQ-023 While rst_n is low, memReady and aluReady SHALL be 0.
REQ-024 Reset mid-operation SHALL discard all queued entries; no write SHALL be issued after reset for a pre-reset entry.

Configuration
REQ-025 Macro WB_FORWARD_EN SHALL enable forwarding ports fwdReg1, fwdReg2 (input 5), fwdHit1, fwdHit2 (output 1), fwdData1, fwdData2 (output 64).
REQ-026 With WB_FORWARD_EN, fwdHitN SHALL be combinationally 1 when fwdRegN != 0 matches a queued entry or the write-port register while allowWrite=1.
REQ-027 With WB_FORWARD_EN, fwdDataN SHALL return the youngest match (queue tail side first, write-port register last); 0 when no hit.
REQ-028 Without WB_FORWARD_EN the forwarding ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Single ALU write x5=0x1234 into empty queue at edge N -> allowWrite=1, writeReg=5, writeData=0x1234 after edge N+1 only.
REQ-030 mem x3=0xAA and ALU x4=0xBB same cycle, empty queue -> writes x3 then x4 on consecutive cycles; count 2 then 1 then 0.
REQ-031 DEPTH=4, 5 back-to-back ALU writes with the port draining -> count never exceeds 4; all 5 writes issued in order, none lost.
REQ-032 Fill to count=3, both valid -> memReady=1, aluReady=0; mem accepted, ALU held and accepted later.
REQ-033 ALU write to x0 with data 0xFF -> handshake completes, count unchanged, allowWrite stays 0.
REQ-034 Assert rst_n low with 3 entries queued -> count=0, allowWrite=0 immediately; no stale writes after release; with WB_FORWARD_EN, queue x7=1 then x7=2 -> fwdReg1=7 returns fwdHit1=1, fwdData1=2.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Writeback bundle: load-unit and ALU result channels, register-file write port, occupancy.
// slave is the queue side, master is the producer/consumer side.
interface regfile_writeback_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          memValid;
  logic [4:0]    memReg;
  logic [63:0]   memData;
  logic          memReady;
  logic          aluValid;
  logic [4:0]    aluReg;
  logic [63:0]   aluData;
  logic          aluReady;
  logic [4:0]    writeReg;
  logic [63:0]   writeData;
  logic          allowWrite;
  logic [CW-1:0] count;

  modport slave (
    input  memValid, memReg, memData, aluValid, aluReg, aluData,
    output memReady, aluReady, writeReg, writeData, allowWrite, count
  );

  modport master (
    output memValid, memReg, memData, aluValid, aluReg, aluData,
    input  memReady, aluReady, writeReg, writeData, allowWrite, count
  );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback queue merging load-unit and ALU results into one register-file write port.
// Up to two enqueues (mem first, then ALU) and one pop per cycle; writes to x0 are dropped.
// Optional macro WB_FORWARD_EN adds two combinational forwarding lookup ports.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_writeback_if.slave   wb
`ifdef WB_FORWARD_EN
  ,
  input  logic [4:0]           fwdReg1,
  input  logic [4:0]           fwdReg2,
  output logic                 fwdHit1,
  output logic                 fwdHit2,
  output logic [63:0]          fwdData1,
  output logic [63:0]          fwdData2
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [CW-1:0] DepthM1C = CW'(DEPTH - 1);

  logic [4:0]    q_reg_q  [DEPTH];
  logic [63:0]   q_data_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, alu_slot;
  logic [CW-1:0] count_q, count_d;
  logic          mem_rdy, alu_rdy, mem_enq, alu_enq, pop;
  logic [4:0]    wr_reg_q;
  logic [63:0]   wr_data_q;
  logic          wr_en_q;

  // Readiness from registered count only; both forced low while in reset.
  always_comb begin
    mem_rdy  = rst_n && (count_q < DepthC);
    alu_rdy  = rst_n && ((count_q < DepthM1C) || ((count_q < DepthC) && !wb.memValid));
    mem_enq  = wb.memValid && mem_rdy && (wb.memReg != 5'd0);
    alu_enq  = wb.aluValid && alu_rdy && (wb.aluReg != 5'd0);
    pop      = (count_q != '0);
    // ALU entry lands behind the mem entry when both enqueue.
    alu_slot = wptr_q + AW'(mem_enq);
    wptr_d   = wptr_q + AW'(mem_enq) + AW'(alu_enq);
    rptr_d   = rptr_q + AW'(pop);
    count_d  = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);
  end

  assign wb.memReady   = mem_rdy;
  assign wb.aluReady   = alu_rdy;
  assign wb.writeReg   = wr_reg_q;
  assign wb.writeData  = wr_data_q;
  assign wb.allowWrite = wr_en_q;
  assign wb.count      = count_q;

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      wr_en_q <= pop;
      if (pop) begin
        wr_reg_q  <= q_reg_q[rptr_q];
        wr_data_q <= q_data_q[rptr_q];
      end
    end
  end

  // Queue storage; validity is tracked by pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      q_reg_q[wptr_q]  <= wb.memReg;
      q_data_q[wptr_q] <= wb.memData;
    end
    if (alu_enq) begin
      q_reg_q[alu_slot]  <= wb.aluReg;
      q_data_q[alu_slot] <= wb.aluData;
    end
  end

`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_reg  [2];
  logic        fwd_hit  [2];
  logic [63:0] fwd_data [2];

  assign fwd_reg[0] = fwdReg1;
  assign fwd_reg[1] = fwdReg2;
  assign fwdHit1    = fwd_hit[0];
  assign fwdHit2    = fwd_hit[1];
  assign fwdData1   = fwd_data[0];
  assign fwdData2   = fwd_data[1];

  // Scan oldest to youngest so the youngest match wins; write-port register is oldest.
  always_comb begin
    logic [AW-1:0] idx;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      if (fwd_reg[p] != 5'd0) begin
        if (wr_en_q && (wr_reg_q == fwd_reg[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = wr_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = rptr_q + AW'(i);
          if ((CW'(i) < count_q) && (q_reg_q[idx] == fwd_reg[p])) begin
            fwd_hit[p]  = 1'b1;
            fwd_data[p] = q_data_q[idx];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH=4).
// Define WB_FORWARD_EN to also exercise the forwarding ports.
module tb_regfile_writeback;
  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  regfile_writeback_if #(.DEPTH(4)) wb ();

`ifdef WB_FORWARD_EN
  logic [4:0]  fwdReg1, fwdReg2;
  logic        fwdHit1, fwdHit2;
  logic [63:0] fwdData1, fwdData2;
`endif

  regfile_writeback #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
`ifdef WB_FORWARD_EN
    ,
    .fwdReg1  (fwdReg1),
    .fwdReg2  (fwdReg2),
    .fwdHit1  (fwdHit1),
    .fwdHit2  (fwdHit2),
    .fwdData1 (fwdData1),
    .fwdData2 (fwdData2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [63:0] md,
                       input logic av, input logic [4:0] ar, input logic [63:0] ad);
    wb.memValid = mv;
    wb.memReg   = mr;
    wb.memData  = md;
    wb.aluValid = av;
    wb.aluReg   = ar;
    wb.aluData  = ad;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Write-port contents after an edge.
  task automatic check_wr(input string tag, input logic en, input logic [4:0] r,
                          input logic [63:0] d);
    check({tag, ".en"}, 64'(wb.allowWrite), 64'(en));
    check({tag, ".reg"}, 64'(wb.writeReg), 64'(r));
    check({tag, ".data"}, wb.writeData, d);
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
`ifdef WB_FORWARD_EN
    fwdReg1 = 5'd0;
    fwdReg2 = 5'd0;
`endif
    #3 rst_n = 1'b0;
    #1;
    // Reset state, readies low while in reset
    check("rst.count", 64'(wb.count), 64'd0);
    check_wr("rst", 1'b0, 5'd0, 64'd0);
    wb.memValid = 1'b1;
    #1;
    check("rst.memReady", 64'(wb.memReady), 64'd0);
    check("rst.aluReady", 64'(wb.aluReady), 64'd0);
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Single ALU write, one-cycle latency
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h1234);
    #1;
    check("alu1.aluReady", 64'(wb.aluReady), 64'd1);
    tick();
    idle();
    check("alu1.count", 64'(wb.count), 64'd1);
    check("alu1.en_early", 64'(wb.allowWrite), 64'd0);
    tick();
    check_wr("alu1.w", 1'b1, 5'd5, 64'h1234);
    check("alu1.count0", 64'(wb.count), 64'd0);
    tick();
    check_wr("alu1.hold", 1'b0, 5'd5, 64'h1234);

    // Simultaneous mem and ALU: mem goes first
    drive(1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'hBB);
    tick();
    idle();
    check("dual.count2", 64'(wb.count), 64'd2);
    tick();
    check("dual.count1", 64'(wb.count), 64'd1);
    check_wr("dual.w0", 1'b1, 5'd3, 64'hAA);
    tick();
    check("dual.count0", 64'(wb.count), 64'd0);
    check_wr("dual.w1", 1'b1, 5'd4, 64'hBB);
    tick();
    check("dual.idle", 64'(wb.allowWrite), 64'd0);

    // Write to x0: handshake only
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF);
    #1;
    check("x0.aluReady", 64'(wb.aluReady), 64'd1);
    tick();
    idle();
    check("x0.count", 64'(wb.count), 64'd0);
    check("x0.en", 64'(wb.allowWrite), 64'd0);
    tick();
    check("x0.en2", 64'(wb.allowWrite), 64'd0);

    // Fill to 3, mem wins the last slot, ALU held then accepted
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
    tick();
    check("fill.count2", 64'(wb.count), 64'd2);
    drive(1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77);
    tick();
    check("fill.count3", 64'(wb.count), 64'd3);
    drive(1'b1, 5'd8, 64'h88, 1'b1, 5'd9, 64'h99);
    #1;
    check("fill.memReady", 64'(wb.memReady), 64'd1);
    check("fill.aluReady", 64'(wb.aluReady), 64'd0);
    tick();
    check("fill.countC", 64'(wb.count), 64'd3);
    check_wr("fill.w2", 1'b1, 5'd2, 64'h22);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99);
    #1;
    check("fill.aluReady2", 64'(wb.aluReady), 64'd1);
    tick();
    idle();
    check("fill.countD", 64'(wb.count), 64'd3);
    check_wr("fill.w6", 1'b1, 5'd6, 64'h66);
    tick();
    check_wr("fill.w7", 1'b1, 5'd7, 64'h77);
    tick();
    check_wr("fill.w8", 1'b1, 5'd8, 64'h88);
    tick();
    check_wr("fill.w9", 1'b1, 5'd9, 64'h99);
    check("fill.count0", 64'(wb.count), 64'd0);
    tick();
    check("fill.idle", 64'(wb.allowWrite), 64'd0);

    // Five back-to-back ALU writes while draining
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) drive(1'b0, 5'd0, 64'd0, 1'b1, 5'(10 + k), 64'(256 + k));
      else idle();
      #1;
      if (k < 5) check($sformatf("b2b%0d.ready", k), 64'(wb.aluReady), 64'd1);
      tick();
      check($sformatf("b2b%0d.count", k), 64'(wb.count), (k < 5) ? 64'd1 : 64'd0);
      if (k > 0) check_wr($sformatf("b2b%0d", k), 1'b1, 5'(10 + k - 1), 64'(256 + k - 1));
    end
    tick();
    check("b2b.idle", 64'(wb.allowWrite), 64'd0);

`ifdef WB_FORWARD_EN
    // Forwarding returns the youngest match
    drive(1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2);
    tick();
    idle();
    fwdReg1 = 5'd7;
    fwdReg2 = 5'd9;
    #1;
    check("fwd.q.hit1", 64'(fwdHit1), 64'd1);
    check("fwd.q.data1", fwdData1, 64'd2);
    check("fwd.q.hit2", 64'(fwdHit2), 64'd0);
    check("fwd.q.data2", fwdData2, 64'd0);
    tick();
    check("fwd.mix.data1", fwdData1, 64'd2);
    tick();
    check("fwd.wp.hit1", 64'(fwdHit1), 64'd1);
    check("fwd.wp.data1", fwdData1, 64'd2);
    tick();
    check("fwd.none.hit1", 64'(fwdHit1), 64'd0);
    check("fwd.none.data1", fwdData1, 64'd0);
    fwdReg1 = 5'd0;
    fwdReg2 = 5'd0;
`endif

    // Reset mid-operation discards queued entries
    drive(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102);
    tick();
    drive(1'b1, 5'd3, 64'h103, 1'b1, 5'd4, 64'h104);
    tick();
    idle();
    check("mid.count3", 64'(wb.count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid.count", 64'(wb.count), 64'd0);
    check_wr("mid.rst", 1'b0, 5'd0, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("mid.stale%0d", k), 64'(wb.allowWrite), 64'd0);
    end
    check("mid.count_after", 64'(wb.count), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
